// File: rtl/adc_avg_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_avg_fifo_if
// Description : Sample, config and read-port bundle for adc_avg_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_avg_fifo_if;
  logic        smp_valid;
  logic [11:0] smp_data;
  logic [2:0]  smp_ch;
  logic        cfg_wr;
  logic [31:0] cfg_data;
  logic        rd_pop;
  logic [31:0] rd_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic        busy;

  modport master (
    output smp_valid, smp_data, smp_ch, cfg_wr, cfg_data, rd_pop,
    input  rd_data, fifo_empty, fifo_full, busy
  );

  modport slave (
    input  smp_valid, smp_data, smp_ch, cfg_wr, cfg_data, rd_pop,
    output rd_data, fifo_empty, fifo_full, busy
  );
endinterface
`default_nettype wire

// File: rtl/adc_avg_fifo.sv
`default_nettype none
// ============================================================================
// Module      : adc_avg_fifo
// Description : Per-channel power-of-two sample averager feeding a show-ahead
//               FIFO drained through a single registered read word.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_avg_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DW         = 12,
  parameter int MAX_LOG2   = 7
) (
  input  logic           clk,
  input  logic           rst,
  adc_avg_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ENT_W = DW + 3;
  localparam int ACC_W = DW + MAX_LOG2;
  localparam int CNT_W = MAX_LOG2 + 1;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  logic [2:0]            avg_log2_q, avg_log2_d;
  logic                  enable_q, enable_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            win_ch_q, win_ch_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic [ENT_W-1:0]      mem_q [DEPTH];

  logic [CNT_W-1:0] win_size, base_cnt, cnt_inc;
  logic [ACC_W-1:0] base_acc, sum, shifted;
  logic             restart, clear, push_req, push, pop;
  logic [ENT_W-1:0] entry, head;
  logic             unused_cfg_bits;

  assign unused_cfg_bits = &{1'b0, bus.cfg_data[31:5]};

  always_comb begin
    avg_log2_d = avg_log2_q;
    enable_d   = enable_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    win_ch_d   = win_ch_q;
    push_req   = 1'b0;

    // A tag change mid-window abandons the old partial sum entirely.
    win_size = CNT_W'(1) << avg_log2_q;
    restart  = (cnt_q != '0) && (bus.smp_ch != win_ch_q);
    base_acc = restart ? '0 : acc_q;
    base_cnt = restart ? '0 : cnt_q;
    sum      = base_acc + ACC_W'(bus.smp_data);
    cnt_inc  = base_cnt + CNT_W'(1);
    shifted  = sum >> avg_log2_q;
    entry    = {bus.smp_ch, shifted[DW-1:0]};
    clear    = bus.cfg_wr && bus.cfg_data[4];

    if (bus.cfg_wr) begin
      avg_log2_d = bus.cfg_data[2:0];
      enable_d   = bus.cfg_data[3];
      acc_d      = '0;
      cnt_d      = '0;
    end else if (enable_q && bus.smp_valid) begin
      win_ch_d = bus.smp_ch;
      if (cnt_inc == win_size) begin
        push_req = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
      end
    end

    pop  = bus.rd_pop && (level_q != '0) && !clear;
    push = push_req && ((level_q != LVL_W'(DEPTH)) || pop);

    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    ovf_d    = ovf_q | (push_req & ~push);

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end

    // Bypass the write port when the new entry becomes the head this edge.
    head = (push && (wr_ptr_q == rd_ptr_d)) ? entry : mem_q[rd_ptr_d];

    rd_data_d                = '0;
    rd_data_d[31]            = ovf_d;
    rd_data_d[16 +: LVL_W]   = level_d;
    if (level_d != '0) begin
      rd_data_d[15]          = 1'b1;
      rd_data_d[ENT_W-1:0]   = head;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      avg_log2_q <= '0;
      enable_q   <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      win_ch_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      avg_log2_q <= avg_log2_d;
      enable_q   <= enable_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      win_ch_q   <= win_ch_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= entry;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.fifo_empty = (level_q == '0);
  assign bus.fifo_full  = (level_q == LVL_W'(DEPTH));
  assign bus.busy       = (cnt_q != '0);

endmodule
`default_nettype wire
